if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Instruction-fetch stage. Owns the PC, issues requests to instruction memory over a req/ack handshake, and presents instruction and PC+1 to the IF/ID pipeline register together with that register's notEnable and clear controls. Sits between the instruction memory and IF/ID, and accepts redirects from the branch/jump logic and stalls from the hazard unit.

Parameters:
PC_W, 8, PC and instruction-address width
INST_W, 32, instruction width
RESET_PC, 0, PC value after reset
HALT_OPCODE, 6'h3F, opcode in bits [31:26] that stops fetching

Ports:
clock  in  1  system clock; this block updates on the rising edge, IF/ID captures on the falling edge
reset  in  1  asynchronous, active-high
stall_in  in  1  hazard unit: IF/ID must hold
redirect  in  1  taken branch or jump this cycle
redirect_target  in  PC_W  new PC on redirect
imem_req  out  1  fetch request
imem_addr  out  PC_W  fetch address; stable while imem_req=1 and imem_ack=0
imem_ack  in  1  imem_rdata valid this cycle; may be asserted in the same cycle as imem_req
imem_rdata  in  INST_W  fetched word
instruction_out  out  INST_W  to IF/ID instruction
pc_next_out  out  PC_W  to IF/ID pcNext: address of the presented instruction + 1, mod 2^PC_W
if_not_enable  out  1  to IF/ID notEnable; equals stall_in
if_clear  out  1  to IF/ID clear; 1 when no valid instruction is presented, or when redirect=1
halted  out  1  fetch stopped

Behaviour:
- Registers: pc, req_addr, inst_buf, inst_pc, inst_valid, state in {FETCH, DRAIN, HALTED}.
- Reset (asynchronous): pc=RESET_PC, req_addr=RESET_PC, inst_buf=0, inst_pc=0, inst_valid=0, state=FETCH.
- Output values during reset: imem_req=0, instruction_out=0, pc_next_out=1, if_clear=1, halted=0.
- instruction_out=inst_buf; pc_next_out=inst_pc+1, wrapping 0xFF->0x00.
- FETCH:
  - imem_req=1 unless (inst_valid & stall_in). imem_addr=req_addr, where req_addr tracks pc.
  - On rising edge with imem_ack: inst_buf<=imem_rdata; inst_pc<=pc; inst_valid<=1; pc<=pc+1 (wraps).
  - If imem_rdata[31:26]==HALT_OPCODE, also go to HALTED. The halt word itself is presented.
  - On rising edge with inst_valid & ~stall_in & ~imem_ack: inst_valid<=0, since IF/ID consumed the word on the preceding falling edge.
- Throughput and latency:
  - With zero-wait memory (ack in the request cycle), one instruction per cycle.
  - Data acked at rising edge N is presented after N and captured by IF/ID at the falling edge of cycle N.
- Stall: inst_valid & stall_in holds inst_buf and pc and sends no request; IF/ID holds because if_not_enable=1.
- Redirect has priority over stall and ack. On a rising edge with redirect=1: pc<=redirect_target, inst_valid<=0.
  - If imem_req=1 and imem_ack=0 at that edge: go to DRAIN and keep req_addr (a request is still in flight).
  - Otherwise: req_addr<=redirect_target and stay in or enter FETCH.
  - Also while redirect=1, if_clear=1 combinationally.
- DRAIN: imem_req=1 at the old req_addr. On ack: discard the data, set req_addr<=pc, go to FETCH. A further redirect while in DRAIN only updates pc.
- HALTED:
  - imem_req=0 and halted=1.
  - inst_valid clears once the word is consumed (same rule as in FETCH).
  - A redirect returns to FETCH, because the halt was wrong-path. Otherwise only reset exits HALTED.
- Reset mid-transaction: the in-flight request is abandoned. Instruction memory is reset by the same signal.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs perf_fetch_cnt[31:0] (accepted acks in FETCH), perf_stall_cnt[31:0] (cycles with inst_valid & stall_in) and perf_flush_cnt[15:0] (redirects).
  - All counters reset to 0 and saturate at their maximum value.
- Undefined: these ports and the counters do not exist.

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum
  - HALT_OPCODE and opcode field position [31:26]
  - PC_W and INST_W defaults
- Sub-module fetch_perf_counters, instantiated only under FETCH_PERF_CNT_EN. The core FSM stays in one module.

Test Plan:
- Reset, zero-wait memory returning word=addr: imem_addr 0,1,2,3 on consecutive cycles; IF/ID sees pc_next_out 1,2,3,4; if_clear=0 after the first ack.
- stall_in=1 for 3 cycles while inst_pc=5: imem_req=0, instruction_out held, if_not_enable=1; fetch resumes at addr 6.
- 3-cycle-latency memory, redirect to 0x40 while a request for 0x07 is pending: DRAIN keeps imem_addr=0x07; its data is never presented; the next request is at 0x40; if_clear=1 throughout.
- PC=0xFF: fetch at 0xFF gives pc_next_out=0x00, and the next imem_addr=0x00.
- Word with [31:26]=6'h3F at addr 3: presented once, halted=1, no further imem_req; a redirect to 0x10 resumes fetch at 0x10.
- Assert reset while in DRAIN: all outputs return to reset values asynchronously; the first request after release is at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch stage.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
package cpu_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int INST_W_DEF = 32;
    localparam int OPC_HI     = 31;
    localparam int OPC_LO     = 26;

    localparam logic [5:0] HALT_OPC_DEF = 6'h3F;

    typedef enum logic [1:0] {
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating event counters for the fetch stage.
// Instantiated only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (fetch_inc && perf_fetch_cnt != '1)
                perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
            if (stall_inc && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 1'b1;
            if (flush_inc && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, imem req/ack, IF/ID controls.
// Define FETCH_PERF_CNT_EN to add saturating perf counters.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W        = PC_W_DEF,
    parameter int              INST_W      = INST_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]      HALT_OPCODE = HALT_OPC_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_target,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instruction_out,
    output logic [PC_W-1:0]   pc_next_out,
    output logic              if_not_enable,
    output logic              if_clear,
    output logic              halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    fetch_state_t state, state_n;

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   req_addr;
    logic [INST_W-1:0] inst_buf;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_valid;
    logic              req_c;
    logic              is_halt;
    logic              consume;
    logic              in_flight;

    assign is_halt   = imem_rdata[OPC_HI:OPC_LO] == HALT_OPCODE;
    assign consume   = inst_valid & ~stall_in;
    assign in_flight = req_c & ~imem_ack;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        req_c   = 1'b0;
        unique case (state)
            FETCH: begin
                req_c = ~(inst_valid & stall_in);
                if (req_c && imem_ack && is_halt)
                    state_n = HALTED;
            end
            DRAIN: begin
                req_c = 1'b1;
                if (imem_ack) state_n = FETCH;
            end
            HALTED: req_c = 1'b0;
            default: state_n = FETCH;
        endcase
        // A request left un-acked by a redirect must be drained first
        if (redirect) state_n = in_flight ? DRAIN : FETCH;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            req_addr   <= RESET_PC;
            inst_buf   <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_target;
            inst_valid <= 1'b0;
            if (!in_flight) req_addr <= redirect_target;
        end else begin
            unique case (state)
                FETCH: begin
                    if (req_c && imem_ack) begin
                        inst_buf   <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        pc         <= pc + 1'b1;
                        req_addr   <= pc + 1'b1;
                    end else if (consume) begin
                        inst_valid <= 1'b0;
                    end
                end
                DRAIN: if (imem_ack) req_addr <= pc;
                HALTED: if (consume) inst_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign imem_req        = req_c & ~reset;
    assign imem_addr       = req_addr;
    assign instruction_out = inst_buf;
    assign pc_next_out     = inst_pc + 1'b1;
    assign if_not_enable   = stall_in;
    assign if_clear        = ~inst_valid | redirect;
    assign halted          = state == HALTED;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counters u_perf (
        .clock          (clock),
        .reset          (reset),
        .fetch_inc      (state == FETCH && !redirect && req_c && imem_ack),
        .stall_inc      (inst_valid & stall_in),
        .flush_inc      (redirect),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed test of if_fetch_unit against a variable-latency imem model.
// Memory returns word=addr; optional halt word at address 3.
module tb_if_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect;
    logic [7:0]  redirect_target;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction_out;
    logic [7:0]  pc_next_out;
    logic        if_not_enable;
    logic        if_clear;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int lat   = 0;
    int cnt;
    logic halt_en = 1'b0;

    always #5 clock = ~clock;

    if_fetch_unit dut (
        .clock           (clock),
        .reset           (reset),
        .stall_in        (stall_in),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instruction_out (instruction_out),
        .pc_next_out     (pc_next_out),
        .if_not_enable   (if_not_enable),
        .if_clear        (if_clear),
        .halted          (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    // imem model: ack after `lat` wait cycles, same cycle when lat=0
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                     cnt <= 0;
        else if (imem_req && !imem_ack) cnt <= cnt + 1;
        else                           cnt <= 0;
    end

    assign imem_ack = imem_req && (cnt >= lat);

    always_comb begin
        imem_rdata = {24'h0, imem_addr};
        if (halt_en && imem_addr == 8'h03)
            imem_rdata = {6'h3F, 18'h0, imem_addr};
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall_in = 1'b0;
        redirect = 1'b0;
        redirect_target = 8'h00;
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_inst", instruction_out, 32'd0);
        check("rst_pcn", 32'(pc_next_out), 32'd1);
        check("rst_clr", 32'(if_clear), 32'd1);
        check("rst_halt", 32'(halted), 32'd0);
        step();
        reset = 1'b0;
        #1;

        // zero-wait streaming
        check("s_addr0", 32'(imem_addr), 32'd0);
        check("s_clr0", 32'(if_clear), 32'd1);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("s_addr", 32'(imem_addr), 32'(k));
            check("s_pcn", 32'(pc_next_out), 32'(k));
            check("s_inst", instruction_out, 32'(k - 1));
            check("s_clr", 32'(if_clear), 32'd0);
        end

        // stall with inst_pc=5
        stall_in = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("st_req", 32'(imem_req), 32'd0);
            check("st_inst", instruction_out, 32'd5);
            check("st_ne", 32'(if_not_enable), 32'd1);
            step();
        end
        stall_in = 1'b0;
        #1;
        check("st_resume", 32'(imem_addr), 32'd6);
        check("st_rreq", 32'(imem_req), 32'd1);
        step();
        check("st_inst6", instruction_out, 32'd6);
        check("st_pcn7", 32'(pc_next_out), 32'd7);

        // redirect while 0x07 in flight, 3-cycle memory
        lat = 3;
        #1;
        check("dr_ack0", 32'(imem_ack), 32'd0);
        check("dr_addr7", 32'(imem_addr), 32'd7);
        step();
        check("dr_clr_a", 32'(if_clear), 32'd1);
        redirect = 1'b1;
        redirect_target = 8'h40;
        #1;
        check("dr_clr_r", 32'(if_clear), 32'd1);
        step();
        redirect = 1'b0;
        #1;
        check("dr_keep", 32'(imem_addr), 32'd7);
        check("dr_req", 32'(imem_req), 32'd1);
        check("dr_clr_b", 32'(if_clear), 32'd1);
        step();
        check("dr_ack7", 32'(imem_ack), 32'd1);
        check("dr_keep2", 32'(imem_addr), 32'd7);
        step();
        check("dr_new", 32'(imem_addr), 32'h40);
        check("dr_nopres", instruction_out, 32'd6);
        check("dr_clr_c", 32'(if_clear), 32'd1);
        step();
        step();
        check("dr_clr_d", 32'(if_clear), 32'd1);
        step();
        check("dr_ack40", 32'(imem_ack), 32'd1);
        step();
        check("dr_inst40", instruction_out, 32'h40);
        check("dr_pcn41", 32'(pc_next_out), 32'h41);
        check("dr_clr0", 32'(if_clear), 32'd0);

        // PC wrap at 0xFF
        lat = 0;
        redirect = 1'b1;
        redirect_target = 8'hFE;
        step();
        redirect = 1'b0;
        #1;
        check("w_addrFE", 32'(imem_addr), 32'hFE);
        step();
        check("w_addrFF", 32'(imem_addr), 32'hFF);
        step();
        check("w_inst", instruction_out, 32'hFF);
        check("w_pcn", 32'(pc_next_out), 32'h00);
        check("w_addr0", 32'(imem_addr), 32'h00);

        // halt word at address 3
        halt_en = 1'b1;
        redirect = 1'b1;
        redirect_target = 8'h00;
        step();
        redirect = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) step();
        check("h_inst", instruction_out, 32'hFC000003);
        check("h_pcn", 32'(pc_next_out), 32'd4);
        check("h_clr", 32'(if_clear), 32'd0);
        check("h_halt", 32'(halted), 32'd1);
        check("h_req", 32'(imem_req), 32'd0);
        step();
        check("h_once", 32'(if_clear), 32'd1);
        check("h_req2", 32'(imem_req), 32'd0);
        step();
        check("h_req3", 32'(imem_req), 32'd0);
        redirect = 1'b1;
        redirect_target = 8'h10;
        step();
        redirect = 1'b0;
        #1;
        check("h_resume", 32'(halted), 32'd0);
        check("h_addr10", 32'(imem_addr), 32'h10);
        check("h_rreq", 32'(imem_req), 32'd1);
        step();
        check("h_inst10", instruction_out, 32'h10);

        // async reset while draining
        halt_en = 1'b0;
        lat = 3;
        redirect = 1'b1;
        redirect_target = 8'h20;
        step();
        redirect = 1'b0;
        #1;
        check("ar_drain", 32'(imem_addr), 32'h11);
        #2;
        reset = 1'b1;
        #1;
        check("ar_req", 32'(imem_req), 32'd0);
        check("ar_inst", instruction_out, 32'd0);
        check("ar_pcn", 32'(pc_next_out), 32'd1);
        check("ar_clr", 32'(if_clear), 32'd1);
        check("ar_halt", 32'(halted), 32'd0);
        step();
        lat = 0;
        reset = 1'b0;
        #1;
        check("ar_addr", 32'(imem_addr), 32'd0);
        check("ar_rreq", 32'(imem_req), 32'd1);
        step();
        check("ar_inst0", instruction_out, 32'd0);
        check("ar_pcn1", 32'(pc_next_out), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
